// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with lane alignment, timeout and exceptions
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;

  logic        illegal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign op_ready = (state == IDLE);
  assign stall    = op_valid & ~op_ready;

  always_comb begin
    illegal    = 1'b0;
    be_next    = 4'b1111;
    wdata_next = store_data;
    case (op_size)
      2'b00: begin
        be_next    = 4'b0001 << alu_result[1:0];
        wdata_next = {4{store_data[7:0]}};
      end
      2'b01: begin
        illegal    = alu_result[0];
        be_next    = 4'b0011 << alu_result[1:0];
        wdata_next = {2{store_data[15:0]}};
      end
      2'b10:   illegal = |alu_result[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by size.
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = mem_rdata;
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'h000000, shifted[7:0]};
      2'b01:   load_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'h0000, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      rd_q      <= 5'd0;
      addr_q    <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      exc_valid <= 1'b0;
      exc_code  <= 2'b00;
      exc_addr  <= 32'd0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (illegal) begin
              exc_valid <= 1'b1;
              exc_code  <= op_load ? 2'b01 : 2'b10;
              exc_addr  <= alu_result;
            end else begin
              state     <= ACCESS;
              cnt       <= 8'd0;
              off_q     <= alu_result[1:0];
              size_q    <= op_size;
              signed_q  <= op_signed;
              rd_q      <= op_rd;
              addr_q    <= alu_result;
              mem_req   <= 1'b1;
              mem_we    <= ~op_load;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end
        ACCESS: begin
          // A ready on the last allowed cycle wins over the timeout.
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= load_data;
            end
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            exc_valid <= 1'b1;
            exc_code  <= 2'b11;
            exc_addr  <= addr_q;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
